// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the requester, response and ALU-side signals of the shared-ALU front end.
// Ports: none (pure signal bundle). slave = arbiter view, master = requesters/consumer/ALU view.
// req_* = two packed requester lanes, rsp_* = shared tagged response channel, alu_* = ALU drive/return.
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [11:0] req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [5:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_zero;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, alu_a, alu_b, alu_op
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_zero,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end for the shared 16-bit ALU, one op in flight, tagged response.
// Latency: legal op responds LAT edges after accept (MULDIV_LAT for MUL/DIV/MOD, else BASIC_LAT);
//          rejected op responds on the accept edge. Backpressure: response held until rsp_ready; no accept until IDLE.
// Ports: clk, rst_n (async active-low), bus (alu_arbiter_if.slave: req_*, rsp_*, alu_*).
module alu_arbiter #(
  parameter int unsigned MULDIV_LAT = 3,
  parameter int unsigned BASIC_LAT  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] LAT_MD    = MULDIV_LAT[3:0];
  localparam logic [3:0] LAT_BASIC = BASIC_LAT[3:0];

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_MUL = 6'h07;
  localparam logic [5:0] OP_DIV = 6'h08;
  localparam logic [5:0] OP_MOD = 6'h09;
  localparam logic [5:0] OP_CMP = 6'h0F;
  localparam logic [5:0] OP_INC = 6'h11;
  localparam logic [5:0] OP_DEC = 6'h12;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        cur_id;

  logic [1:0]  grant;
  logic        gnt_id;
  logic        accept;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic [5:0]  sel_op;
  logic        op_legal;
  logic        div_zero;
  logic        is_muldiv;

  logic [15:0] b_eff;
  logic        c_flag;
  logic        v_flag;

  // Grant only in IDLE; on contention the requester not served last wins.
  always_comb begin
    grant = 2'b00;
    if (state == ST_IDLE) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign accept        = |grant;
  assign gnt_id        = grant[1];

  assign sel_a  = gnt_id ? bus.req_a[31:16] : bus.req_a[15:0];
  assign sel_b  = gnt_id ? bus.req_b[31:16] : bus.req_b[15:0];
  assign sel_op = gnt_id ? bus.req_op[11:6] : bus.req_op[5:0];

  assign op_legal  = (sel_op <= OP_DEC) && (sel_op != 6'h0C);
  assign div_zero  = ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b == 16'h0000);
  assign is_muldiv = (sel_op == OP_MUL) || (sel_op == OP_DIV) || (sel_op == OP_MOD);

  // Carry/overflow from the held operands; inc/dec behave as add/sub with B=1.
  always_comb begin
    b_eff  = ((bus.alu_op == OP_INC) || (bus.alu_op == OP_DEC)) ? 16'h0001 : bus.alu_b;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (bus.alu_op)
      OP_ADD, OP_INC: begin
        c_flag = ({1'b0, bus.alu_a} + {1'b0, b_eff}) > 17'h0FFFF;
        v_flag = (bus.alu_a[15] == b_eff[15]) && (bus.alu_result[15] != bus.alu_a[15]);
      end
      OP_SUB, OP_CMP, OP_DEC: begin
        c_flag = bus.alu_a < b_eff;
        v_flag = (bus.alu_a[15] != b_eff[15]) && (bus.alu_result[15] != bus.alu_a[15]);
      end
      default: begin
        c_flag = 1'b0;
        v_flag = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      cnt            <= 4'd0;
      last_grant     <= 1'b1;
      cur_id         <= 1'b0;
      bus.alu_a      <= 16'h0000;
      bus.alu_b      <= 16'h0000;
      bus.alu_op     <= 6'h00;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= 16'h0000;
      bus.rsp_flags  <= 4'h0;
      bus.rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_grant <= gnt_id;
            if (!op_legal || div_zero) begin
              // Rejected ops never reach the ALU registers.
              bus.rsp_valid  <= 1'b1;
              bus.rsp_err    <= 1'b1;
              bus.rsp_result <= 16'h0000;
              bus.rsp_flags  <= 4'h0;
              bus.rsp_id     <= gnt_id;
              state          <= ST_RESP;
            end else begin
              bus.alu_a  <= sel_a;
              bus.alu_b  <= sel_b;
              bus.alu_op <= sel_op;
              cur_id     <= gnt_id;
              cnt        <= is_muldiv ? LAT_MD : LAT_BASIC;
              state      <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            bus.rsp_valid  <= 1'b1;
            bus.rsp_err    <= 1'b0;
            bus.rsp_result <= bus.alu_result;
            bus.rsp_flags  <= {v_flag, c_flag, bus.alu_result[15], bus.alu_zero};
            bus.rsp_id     <= cur_id;
            state          <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic for alu_arbiter against a transaction-level model.
// The model predicts grants, response timing, response contents and held ALU operands.
module tb_alu_arbiter;
  localparam int MD_LAT = 3;
  localparam int BS_LAT = 1;

  logic clk;
  logic rst_n;
  alu_arbiter_if bus();

  alu_arbiter #(.MULDIV_LAT(MD_LAT), .BASIC_LAT(BS_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Environment ALU: plain arithmetic on the registered operands.
  function automatic logic [15:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      6'h00: return a + b;
      6'h01: return a - b;
      6'h02: return a & b;
      6'h03: return a | b;
      6'h04: return a ^ b;
      6'h05: return ~a;
      6'h06: return a << b[3:0];
      6'h07: return p[15:0];
      6'h08: return (b == 16'h0) ? 16'hFFFF : a / b;
      6'h09: return (b == 16'h0) ? a : a % b;
      6'h0A: return a >> b[3:0];
      6'h0B: return ~(a & b);
      6'h0D: return a;
      6'h0E: return b;
      6'h0F: return a - b;
      6'h10: return 16'h0000 - a;
      6'h11: return a + 16'h0001;
      6'h12: return a - 16'h0001;
      default: return 16'h0000;
    endcase
  endfunction

  assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_zero   = (bus.alu_result == 16'h0000);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outcome of one op, from arithmetic on integers (overflow = signed range check).
  function automatic void ref_exec(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op,
                                   output logic [15:0] res, output logic [3:0] fl,
                                   output logic err, output int lat);
    int ua, ub, sa, sb, s;
    logic c, v;
    err = (int'(op) > 18) || (op == 6'h0C) || (((op == 6'h08) || (op == 6'h09)) && (b == 16'h0));
    res = 16'h0;
    fl  = 4'h0;
    lat = 0;
    if (err) return;
    lat = ((op == 6'h07) || (op == 6'h08) || (op == 6'h09)) ? MD_LAT : BS_LAT;
    res = alu_model(a, b, op);
    ua = int'(a);
    ub = ((op == 6'h11) || (op == 6'h12)) ? 1 : int'(b);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    c = 1'b0;
    v = 1'b0;
    if ((op == 6'h00) || (op == 6'h11)) begin
      c = (ua + ub) > 65535;
      s = sa + sb;
      v = (s > 32767) || (s < -32768);
    end else if ((op == 6'h01) || (op == 6'h0F) || (op == 6'h12)) begin
      c = ua < ub;
      s = sa - sb;
      v = (s > 32767) || (s < -32768);
    end
    fl = {v, c, res[15], (res == 16'h0)};
  endfunction

  // Model state.
  bit          m_busy;
  bit          m_lg;
  int          m_due;
  bit          m_id;
  logic [15:0] m_res;
  logic [3:0]  m_fl;
  logic        m_err;
  logic [15:0] m_alu_a, m_alu_b;
  logic [5:0]  m_alu_op;
  int          cyc;

  // Requester and consumer stimulus.
  bit          pv[2];
  logic [15:0] pa[2], pb[2];
  logic [5:0]  pop[2];
  logic        rdy_in;
  logic [1:0]  obs_rdy;

  task automatic model_reset();
    m_busy = 0; m_lg = 1; m_due = 0; m_id = 0;
    m_res = '0; m_fl = '0; m_err = 0;
    m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
    pv[0] = 0; pv[1] = 0;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [5:0] op);
    pv[i] = 1; pa[i] = a; pb[i] = b; pop[i] = op;
  endtask

  task automatic drive();
    bus.req_valid = {pv[1], pv[0]};
    bus.req_a     = {pa[1], pa[0]};
    bus.req_b     = {pb[1], pb[0]};
    bus.req_op    = {pop[1], pop[0]};
    bus.rsp_ready = rdy_in;
  endtask

  // Serve the requester not served last; a lone requester is served directly.
  function automatic logic [1:0] rr_pick(input logic [1:0] v, input bit lg);
    if (v == 2'b11) return (lg == 1'b1) ? 2'b01 : 2'b10;
    return v;
  endfunction

  // One clock cycle: called just after a falling edge, returns just after the next falling edge.
  task automatic tick();
    logic [1:0]  exp_rdy;
    bit          id, rel, exp_v;
    logic [15:0] a, b;
    logic [5:0]  op;
    int          lat;
    rel = 0;
    drive();
    #1;
    exp_rdy = m_busy ? 2'b00 : rr_pick(bus.req_valid, m_lg);
    obs_rdy = bus.req_ready;
    check("req_ready", obs_rdy, exp_rdy);
    if (exp_rdy != 2'b00) begin
      id = exp_rdy[1];
      a  = pa[id]; b = pb[id]; op = pop[id];
      ref_exec(a, b, op, m_res, m_fl, m_err, lat);
      m_busy = 1;
      m_id   = id;
      m_lg   = id;
      m_due  = cyc + 1 + lat;
      if (!m_err) begin
        m_alu_a = a; m_alu_b = b; m_alu_op = op;
      end
      pv[id] = 0;
    end else if (m_busy && (cyc >= m_due) && rdy_in) begin
      rel = 1;
    end
    @(posedge clk);
    cyc++;
    if (rel) m_busy = 0;
    @(negedge clk);
    exp_v = m_busy && (cyc >= m_due);
    check("rsp_valid", bus.rsp_valid, exp_v);
    if (exp_v) begin
      check("rsp_id", bus.rsp_id, m_id);
      check("rsp_result", bus.rsp_result, m_res);
      check("rsp_flags", bus.rsp_flags, m_fl);
      check("rsp_err", bus.rsp_err, m_err);
    end
    check("alu_a", bus.alu_a, m_alu_a);
    check("alu_b", bus.alu_b, m_alu_b);
    check("alu_op", bus.alu_op, m_alu_op);
  endtask

  task automatic drain();
    int n;
    pv[0] = 0; pv[1] = 0; rdy_in = 1;
    n = 0;
    while (m_busy && n < 40) begin
      tick();
      n++;
    end
    check("drain_timeout", m_busy, 0);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_req_ready"}, bus.req_ready, 0);
    check({pfx, "_rsp_valid"}, bus.rsp_valid, 0);
    check({pfx, "_rsp_id"}, bus.rsp_id, 0);
    check({pfx, "_rsp_result"}, bus.rsp_result, 0);
    check({pfx, "_rsp_flags"}, bus.rsp_flags, 0);
    check({pfx, "_rsp_err"}, bus.rsp_err, 0);
    check({pfx, "_alu_a"}, bus.alu_a, 0);
    check({pfx, "_alu_b"}, bus.alu_b, 0);
    check({pfx, "_alu_op"}, bus.alu_op, 0);
  endtask

  initial begin
    int gcnt, n, r;
    int gids[4];
    cyc = 0;
    model_reset();
    pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0; pop[0] = '0; pop[1] = '0;
    rdy_in = 1;
    rst_n = 0;
    drive();
    #3;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Add with signed overflow, requester 0.
    set_req(0, 16'h7FFF, 16'h0001, 6'h00);
    tick();
    tick();
    check("add_valid", bus.rsp_valid, 1);
    check("add_result", bus.rsp_result, 16'h8000);
    check("add_flags", bus.rsp_flags, 4'b1010);
    check("add_id", bus.rsp_id, 0);
    check("add_err", bus.rsp_err, 0);
    drain();

    // Subtract with borrow, requester 1.
    set_req(1, 16'h0003, 16'h0005, 6'h01);
    tick();
    tick();
    check("sub_valid", bus.rsp_valid, 1);
    check("sub_result", bus.rsp_result, 16'hFFFE);
    check("sub_flags", bus.rsp_flags, 4'b0110);
    check("sub_id", bus.rsp_id, 1);
    drain();

    // Continuous contention: grants alternate starting with requester 0.
    gcnt = 0;
    n = 0;
    rdy_in = 1;
    while (gcnt < 4 && n < 40) begin
      set_req(0, 16'h0010, 16'h0020, 6'h00);
      set_req(1, 16'h1000, 16'h0002, 6'h01);
      tick();
      if (obs_rdy != 2'b00) begin
        gids[gcnt] = int'(obs_rdy[1]);
        gcnt++;
      end
      n++;
    end
    check("contention_grants", gcnt, 4);
    for (int k = 0; k < 4; k++) check("contention_order", gids[k], k % 2);
    drain();

    // MUL with latency 3 then 5 cycles of response backpressure.
    set_req(0, 16'd3, 16'd4, 6'h07);
    rdy_in = 0;
    tick();
    tick();
    check("mul_wait1", bus.rsp_valid, 0);
    tick();
    check("mul_wait2", bus.rsp_valid, 0);
    tick();
    check("mul_valid", bus.rsp_valid, 1);
    check("mul_result", bus.rsp_result, 16'd12);
    for (int k = 0; k < 5; k++) begin
      set_req(0, 16'h0001, 16'h0001, 6'h00);
      set_req(1, 16'h0002, 16'h0002, 6'h00);
      tick();
      check("bp_req_ready", obs_rdy, 2'b00);
      check("bp_result", bus.rsp_result, 16'd12);
      check("bp_valid", bus.rsp_valid, 1);
    end
    pv[0] = 0; pv[1] = 0;
    rdy_in = 1;
    tick();
    check("bp_release", bus.rsp_valid, 0);

    // Rejected ops: divide by zero, then reserved opcode.
    set_req(0, 16'h0010, 16'h0000, 6'h08);
    tick();
    check("div0_valid", bus.rsp_valid, 1);
    check("div0_err", bus.rsp_err, 1);
    check("div0_result", bus.rsp_result, 0);
    check("div0_alu_a", bus.alu_a, 16'd3);
    check("div0_alu_b", bus.alu_b, 16'd4);
    check("div0_alu_op", bus.alu_op, 6'h07);
    drain();
    set_req(1, 16'h0055, 16'h0066, 6'h0C);
    tick();
    check("op0c_valid", bus.rsp_valid, 1);
    check("op0c_err", bus.rsp_err, 1);
    check("op0c_flags", bus.rsp_flags, 0);
    check("op0c_alu_op", bus.alu_op, 6'h07);
    drain();

    // Reset during EXEC of a MUL.
    set_req(0, 16'd5, 16'd6, 6'h07);
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    check_zero("midreset");
    model_reset();
    drive();
    @(negedge clk);
    rst_n = 1;
    set_req(0, 16'h0001, 16'h0002, 6'h02);
    set_req(1, 16'h0003, 16'h0004, 6'h03);
    tick();
    check("post_reset_grant", obs_rdy, 2'b01);
    drain();

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 40) begin
          r = $urandom_range(0, 99);
          if (r < 8)       pop[i] = 6'($urandom_range(19, 63));
          else if (r < 12) pop[i] = 6'h0C;
          else             pop[i] = 6'($urandom_range(0, 18));
          r = $urandom_range(0, 5);
          case (r)
            0: pa[i] = 16'h7FFF;
            1: pa[i] = 16'h8000;
            2: pa[i] = 16'hFFFF;
            3: pa[i] = 16'h0000;
            default: pa[i] = 16'($urandom);
          endcase
          pb[i] = ($urandom_range(0, 7) == 0) ? 16'h0000 :
                  ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
          pv[i] = 1;
        end else if (pv[i] && $urandom_range(0, 99) < 5) begin
          pv[i] = 0;
        end
      end
      rdy_in = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
